// File: rtl/updn_pkg.sv
// updn_pkg: shared state encoding and default widths for the up/down sweep controller
package updn_pkg;
  localparam int WIDTH_DEF = 5;
  localparam int SWEEP_W_DEF = 4;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    UP   = 3'd2,
    DOWN = 3'd3,
    DONE = 3'd4
  } state_t;
endpackage

// File: rtl/updn_sweep_ctrl.sv
// updn_sweep_ctrl: runs triangle sweeps Lo..Hi on an external loadable up/down counter
module updn_sweep_ctrl
  import updn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SWEEP_W = SWEEP_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   cfg_start,
  input  logic [WIDTH-1:0]   cfg_lo,
  input  logic [WIDTH-1:0]   cfg_hi,
  input  logic [SWEEP_W-1:0] cfg_sweeps,
  input  logic [WIDTH-1:0]   cnt_value,
  output logic [WIDTH-1:0]   cnt_in,
  output logic               cnt_load,
  output logic               cnt_up,
  output logic               cnt_down,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_cnt
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] start_q, lo_q, hi_q;
  logic [SWEEP_W-1:0] sweeps_q, sweep_inc;
  logic valid, req, at_hi, at_lo, last;
  assign valid = cfg_lo <= cfg_hi && cfg_lo <= cfg_start && cfg_start <= cfg_hi;
  assign req = state == IDLE && start && !abort;
  assign at_hi = cnt_value == hi_q;
  assign at_lo = cnt_value == lo_q;
  assign sweep_inc = sweep_cnt + SWEEP_W'(1);
  assign last = sweeps_q != '0 && sweep_inc == sweeps_q;
  assign cnt_in = state == LOAD ? start_q : '0;
  assign busy = state != IDLE;
  assign done = state == DONE && !abort;
  // abort suppresses every command in the cycle it is seen
  always_comb begin
    state_nxt = state;
    cnt_load = 1'b0;
    cnt_up = 1'b0;
    cnt_down = 1'b0;
    if (abort) state_nxt = IDLE;
    else
      case (state)
        IDLE: state_nxt = start && valid ? LOAD : IDLE;
        LOAD: begin
          cnt_load = 1'b1;
          state_nxt = UP;
        end
        UP: begin
          cnt_up = !at_hi;
          state_nxt = at_hi ? DOWN : UP;
        end
        DOWN: begin
          cnt_down = !at_lo;
          state_nxt = at_lo ? (last ? DONE : UP) : DOWN;
        end
        default: state_nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      start_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      sweeps_q <= '0;
      sweep_cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      err <= req && !valid;
      start_q <= req && valid ? cfg_start : start_q;
      lo_q <= req && valid ? cfg_lo : lo_q;
      hi_q <= req && valid ? cfg_hi : hi_q;
      sweeps_q <= req && valid ? cfg_sweeps : sweeps_q;
      sweep_cnt <= req && valid ? '0 : state == DOWN && at_lo && !abort ? sweep_inc : sweep_cnt;
    end
endmodule
